// File: rtl/sprite_draw_engine_pkg.sv
// Shared types and constants for the sprite draw engine: screen geometry, coordinate widths,
// FSM state encoding, and reset-position / distance helpers.
package sprite_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam logic [2:0] COLOUR_BG = 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE,
      ST_MOVE,
      ST_DRAW,
      ST_DONE
   } state_t;

   // Obstacle start column, folded back onto the visible range for large channel counts.
   function automatic int obs_x0(input int size, input int spacing, input int idx);
      int span;
      int v;
      span = SCREEN_W - size + 1;
      v    = (SCREEN_W - size - (idx - 1) * spacing) % span;
      if (v < 0) v = v + span;
      return v;
   endfunction

   function automatic int obs_y0(input int size, input int idx);
      return (20 * idx) % (SCREEN_H - size);
   endfunction

   function automatic logic [8:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Control and pixel-output bundle between the game controller/VGA adapter and the draw engine.
interface sprite_draw_engine_if;
   import sprite_pkg::*;

   logic           frame_tick;
   logic           enable;
   logic           move_up;
   logic           move_down;
   logic           advance;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [2:0]     colour;
   logic           plot;
   logic           busy;
   logic           pass_done;
   logic           hit;
   logic           finish;

   modport master (
      output frame_tick, enable, move_up, move_down, advance,
      input  x, y, colour, plot, busy, pass_done, hit, finish
   );

   modport slave (
      input  frame_tick, enable, move_up, move_down, advance,
      output x, y, colour, plot, busy, pass_done, hit, finish
   );

endinterface

// File: rtl/sprite_draw_engine_pixel_scan.sv
// Raster counter over one square sprite: column offset in the low bits, row offset in the high bits.
module sprite_pixel_scan #(
   parameter int SIZE_LOG2 = 2
)(
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 i_start,
   output logic [SIZE_LOG2-1:0] o_x_off,
   output logic [SIZE_LOG2-1:0] o_y_off,
   output logic                 o_last
);

   localparam int CW = 2 * SIZE_LOG2;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)      r_cnt <= '0;
      else if (i_start) r_cnt <= '0;
      else              r_cnt <= r_cnt + CW'(1);
   end

   assign o_x_off = r_cnt[SIZE_LOG2-1:0];
   assign o_y_off = r_cnt[CW-1:SIZE_LOG2];
   assign o_last  = &r_cnt;

endmodule

// File: rtl/sprite_draw_engine.sv
// Multi-sprite erase/move/redraw engine for the 160x120 VGA adapter, one pixel per cycle,
// with sticky player/obstacle collision and finish-line detection.
//  state    | meaning
//  ST_IDLE  | waiting for a frame tick (or pending tick) while enabled and not hit/finished
//  ST_ERASE | paint current channel's old square in background colour
//  ST_MOVE  | update current channel's position
//  ST_DRAW  | paint current channel's new square in its colour
//  ST_DONE  | resolve collision and finish on the new positions, pulse pass_done
module sprite_draw_engine
   import sprite_pkg::*;
#(
   parameter int         NUM_SPRITES   = 4,
   parameter int         SIZE_LOG2     = 2,
   parameter int         OBS_SPEED     = 1,
   parameter int         PLAYER_STEP   = 1,
   parameter int         FINISH_X      = 100,
   parameter int         PLAYER_X0     = 10,
   parameter int         PLAYER_Y0     = 58,
   parameter int         OBS_SPACING   = 36,
   parameter logic [2:0] COLOUR_PLAYER = 3'd2,
   parameter logic [2:0] COLOUR_OBS    = 3'd4
)(
   input logic           clock,
   input logic           resetn,
   sprite_draw_engine_if.slave bus
);

   localparam int SIZE   = 2 ** SIZE_LOG2;
   localparam int CH_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int Y_LIM  = SCREEN_H - SIZE;
   localparam int X_WRAP = SCREEN_W - SIZE;

   state_t               r_state, w_state_next;
   logic [CH_W-1:0]      r_ch;
   logic                 r_pending, r_up, r_down, r_adv, r_hit, r_finish;
   logic [X_W-1:0]       r_pos_x [NUM_SPRITES];
   logic [Y_W-1:0]       r_pos_y [NUM_SPRITES];
   logic [X_W-1:0]       r_x, w_cur_x, w_new_x;
   logic [Y_W-1:0]       r_y, w_cur_y, w_new_y;
   logic [7:0]           w_y_wrap;
   logic [2:0]           r_colour;
   logic                 r_plot;
   logic                 w_start, w_last_ch, w_scan_start, w_scan_last, w_plotting, w_coll;
   logic [SIZE_LOG2-1:0] w_x_off, w_y_off;

   sprite_pixel_scan #(.SIZE_LOG2(SIZE_LOG2)) u_scan (
      .clock   (clock),
      .resetn  (resetn),
      .i_start (w_scan_start),
      .o_x_off (w_x_off),
      .o_y_off (w_y_off),
      .o_last  (w_scan_last)
   );

   assign w_start    = (r_state == ST_IDLE) && (bus.frame_tick || r_pending) &&
                       bus.enable && !r_finish && !r_hit;
   assign w_last_ch  = (r_ch == CH_W'(NUM_SPRITES - 1));
   assign w_plotting = (r_state == ST_ERASE) || (r_state == ST_DRAW);
   assign w_cur_x    = r_pos_x[r_ch];
   assign w_cur_y    = r_pos_y[r_ch];

   always_comb begin
      w_state_next = r_state;
      w_scan_start = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (w_start) begin
                      w_state_next = ST_ERASE;
                      w_scan_start = 1'b1;
                   end
         ST_ERASE: if (w_scan_last) w_state_next = ST_MOVE;
         ST_MOVE:  begin
                      w_state_next = ST_DRAW;
                      w_scan_start = 1'b1;
                   end
         ST_DRAW:  if (w_scan_last) begin
                      if (w_last_ch) w_state_next = ST_DONE;
                      else begin
                         w_state_next = ST_ERASE;
                         w_scan_start = 1'b1;
                      end
                   end
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Next position of the channel being processed; only committed in ST_MOVE.
   always_comb begin
      w_new_x  = w_cur_x;
      w_new_y  = w_cur_y;
      w_y_wrap = {1'b0, w_cur_y} + 8'd17;
      if (r_ch == '0) begin
         if (r_up && !r_down)
            w_new_y = (w_cur_y < Y_W'(PLAYER_STEP)) ? '0 : w_cur_y - Y_W'(PLAYER_STEP);
         else if (r_down && !r_up)
            w_new_y = (({1'b0, w_cur_y} + 8'(PLAYER_STEP)) > 8'(Y_LIM)) ?
                      Y_W'(Y_LIM) : w_cur_y + Y_W'(PLAYER_STEP);
         w_new_x = w_cur_x + X_W'(r_adv);
      end else if (w_cur_x < X_W'(OBS_SPEED)) begin
         w_new_x = X_W'(X_WRAP);
         w_new_y = (w_y_wrap >= 8'(Y_LIM)) ? Y_W'(w_y_wrap - 8'(Y_LIM)) : Y_W'(w_y_wrap);
      end else begin
         w_new_x = w_cur_x - X_W'(OBS_SPEED);
      end
   end

   always_comb begin
      w_coll = 1'b0;
      for (int i = 1; i < NUM_SPRITES; i++)
         if (abs_diff9({1'b0, r_pos_x[0]}, {1'b0, r_pos_x[i]}) < 9'(SIZE) &&
             abs_diff9({2'b0, r_pos_y[0]}, {2'b0, r_pos_y[i]}) < 9'(SIZE))
            w_coll = 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_ch      <= '0;
         r_pending <= 1'b0;
         r_up      <= 1'b0;
         r_down    <= 1'b0;
         r_adv     <= 1'b0;
         r_hit     <= 1'b0;
         r_finish  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_up      <= bus.move_up;
            r_down    <= bus.move_down;
            r_adv     <= bus.advance;
            r_ch      <= '0;
            r_pending <= 1'b0;
         end else if (bus.frame_tick && r_state != ST_IDLE) begin
            r_pending <= 1'b1;
         end
         if (r_state == ST_DRAW && w_scan_last && !w_last_ch)
            r_ch <= r_ch + CH_W'(1);
         if (r_state == ST_DONE) begin
            if (w_coll) r_hit <= 1'b1;
            if (r_pos_x[0] > X_W'(FINISH_X)) r_finish <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_pos_x[i] <= (i == 0) ? X_W'(PLAYER_X0) : X_W'(obs_x0(SIZE, OBS_SPACING, i));
            r_pos_y[i] <= (i == 0) ? Y_W'(PLAYER_Y0) : Y_W'(obs_y0(SIZE, i));
         end
      end else if (r_state == ST_MOVE) begin
         r_pos_x[r_ch] <= w_new_x;
         r_pos_y[r_ch] <= w_new_y;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_plot   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= COLOUR_BG;
      end else begin
         r_plot   <= w_plotting;
         r_x      <= w_plotting ? w_cur_x + X_W'(w_x_off) : '0;
         r_y      <= w_plotting ? w_cur_y + Y_W'(w_y_off) : '0;
         r_colour <= (r_state == ST_DRAW) ? ((r_ch == '0) ? COLOUR_PLAYER : COLOUR_OBS) : COLOUR_BG;
      end
   end

   assign bus.x         = r_x;
   assign bus.y         = r_y;
   assign bus.colour    = r_colour;
   assign bus.plot      = r_plot;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.pass_done = (r_state == ST_DONE);
   assign bus.hit       = r_hit;
   assign bus.finish    = r_finish;

endmodule
